// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle radix-2 restoring divider that sits beside the EX stage.
//
// Accepts a signed (DIV) or unsigned (DIVU) request, runs one trial subtraction per cycle and
// presents {remainder, quotient} with ready_o. While a division is pending it raises
// stallreq_o so the stall controller freezes fetch through EX.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   start_i       division request from EX, held until ready_o is seen
//   annul_i       cancel the in-flight division (flush)
//   signed_div_i  1 = signed, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   result_o      {remainder, quotient}
//   ready_o       result valid
//   stallreq_o    stall request toward the stall controller
module div_seq_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StByZero = 2'd1;
    localparam logic [1:0] StOn     = 2'd2;
    localparam logic [1:0] StEnd    = 2'd3;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;      // partial remainder
    logic [DATA_W-1:0]   quo_q, quo_d;      // shifts out dividend bits, shifts in quotient bits
    logic [DATA_W-1:0]   dvs_q, dvs_d;      // |divisor|
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [DATA_W:0]     partial, diff;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // Partial remainder can reach 2*divisor-1 after the shift, hence the extra bit.
    assign partial = {rem_q, quo_q[DATA_W-1]};
    assign diff    = partial - {1'b0, dvs_q};

    assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            StIdle: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = op1_abs;
                    dvs_d     = op2_abs;
                    state_d   = (opdata2_i == '0) ? StByZero : StOn;
                end
            end
            StByZero: begin
                result_d = '0;
                ready_d  = 1'b0;
                state_d  = annul_i ? StIdle : StEnd;
            end
            StOn: begin
                if (annul_i) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q < CntLast) begin
                    cnt_d = cnt_q + 1'b1;
                    if (diff[DATA_W]) begin
                        rem_d = partial[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end else begin
                        rem_d = diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end
                end else begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = StEnd;
                end
            end
            StEnd: begin
                if (annul_i || !start_i) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed vector table, annul/reset sequences and
// randomized operands checked against an arithmetic reference model.
module tb_div_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int errors = 0;
    int checks = 0;

    div_seq_unit #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                           input int lat);
        vec_t v;
        v.name = name; v.sgn = sgn; v.a = a; v.b = b; v.q = q; v.r = r; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, 0 on divide-by-zero.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Called at a negedge; returns at a negedge. lat counts rising edges from the sampling
    // edge t0 (inclusive) up to and including the edge that raises ready_o.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat,
                           input int hold);
        int   n;
        logic done;
        logic stall_bad;
        logic [63:0] res;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        n = 0; done = 1'b0; stall_bad = 1'b0;
        while (n < 100 && !done) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready_o) done = 1'b1;
            else if (!stallreq_o) stall_bad = 1'b1;
            if (n == 1) begin
                // Operands are latched at t0; later changes must not matter.
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
        end
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " stall_while_busy"}, 64'(stall_bad), 64'd0);
        check({name, " stall_at_ready"}, 64'(stallreq_o), 64'd0);
        check({name, " result"}, result_o, exp);
        res = result_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold_result"}, result_o, res);
            check({name, " hold_ready"}, 64'(ready_o), 64'd1);
        end
        start_i = 1'b0;
        @(negedge clk);
        check({name, " idle_ready"}, 64'(ready_o), 64'd0);
        check({name, " idle_result"}, result_o, 64'd0);
    endtask

    initial begin
        int          n;
        logic        bad;
        logic        sgn;
        logic [31:0] a, b;

        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        @(negedge clk);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", 64'(stallreq_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        add_vec("u100_7",        1'b0, 32'd100,        32'd7,          32'h0000000E, 32'd2,          35);
        add_vec("s-7_2",         1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF,   35);
        add_vec("s7_-2",         1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001,   35);
        add_vec("div0",          1'b0, 32'h1234,       32'd0,          32'd0,        32'd0,          3);
        add_vec("s_overflow",    1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'd0,          35);
        add_vec("u_max_1",       1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'd0,          35);
        add_vec("u_big_divisor", 1'b0, 32'hFFFFFFFF,   32'h80000001,   32'd1,        32'h7FFFFFFE,   35);
        add_vec("s-100_-7",      1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,       32'hFFFFFFFE,   35);

        foreach (vecs[i])
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].r, vecs[i].q},
                    vecs[i].lat, (i == 0) ? 3 : 0);

        // Annul during ON at t10: no result ever appears, then a fresh division runs.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        annul_i = 1'b1;
        #1;
        check("annul_suppresses_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o || result_o != 64'd0) bad = 1'b1;
        end
        check("annul_no_result", 64'(bad), 64'd0);
        run_div("after_annul_55_5", 1'b0, 32'd55, 32'd5, {32'd0, 32'd11}, 35, 0);

        // Annul while in END drops the result.
        signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1;
        n = 0;
        while (n < 100 && !ready_o) begin
            @(negedge clk);
            n++;
        end
        check("end_annul_ready_seen", 64'(ready_o), 64'd1);
        annul_i = 1'b1;
        #1;
        check("end_annul_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        check("end_annul_ready", 64'(ready_o), 64'd0);
        check("end_annul_result", result_o, 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        @(negedge clk);

        // Reset mid-division, then start held high begins a fresh division.
        signed_div_i = 1'b0; opdata1_i = 32'h12345678; opdata2_i = 32'h10; start_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div("after_reset", 1'b0, 32'h12345678, 32'h10, {32'h8, 32'h01234567}, 35, 3);

        // Reset while a result is presented clears outputs without waiting for a clock.
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd7; start_i = 1'b1;
        n = 0;
        while (n < 100 && !ready_o) begin
            @(negedge clk);
            n++;
        end
        check("endrst_before_result", result_o, {32'd0, 32'd11});
        #2 rst = 1'b0;
        #1;
        check("endrst_ready", 64'(ready_o), 64'd0);
        check("endrst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized operands against the reference model.
        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'd0;
                2: b = 32'hFFFFFFFF;
                3: begin b = $urandom; a = 32'($urandom_range(0, 1000)); end
                default: b = $urandom;
            endcase
            run_div($sformatf("rand%0d", i), sgn, a, b, model(sgn, a, b),
                    (b == 32'd0) ? 3 : 35, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
